trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Multi-cycle trap sequencer for the single-issue core: arbitrates exception sources from the committing instruction against pending machine interrupts, then walks the CSR update sequence (mepc/mcause/mtval, then mstatus) before redirecting the PC. It also sequences `mret` (mstatus restore, then redirect to mepc). It sits between the decode/commit stage, the CSR file and the PC-select logic, and stalls the core while a sequence is in flight.

## Interface
- `XLEN`, 32, data/address width
- `clk`  in  1  core clock
- `rst_b`  in  1  reset; synchronous, active-low
- `instr_valid`  in  1  instruction at `pc` is committing this cycle
- `pc`  in  XLEN  PC of committing instruction
- `ecall` / `ebreak` / `illegal` / `mret`  in  1 each  decode flags, qualified by `instr_valid`
- `exc_tval`  in  XLEN  faulting instruction bits (for `illegal`)
- `irq_msip` / `irq_mtip` / `irq_meip`  in  1 each  level interrupt pending lines
- `csr_rd_mie_msie` / `csr_rd_mie_mtie` / `csr_rd_mie_meie`  in  1 each  per-source enables
- `csr_rd_mstatus_mie`, `csr_rd_mstatus_mpie`  in  1 each  global enable / previous enable
- `csr_rd_mtvec_base`  in  XLEN-2;  `csr_rd_mtvec_mode`  in  2;  `csr_rd_mepc_mepc`  in  XLEN
- `stall`  out  1  hold fetch/commit
- `trap`  out  1  one-cycle PC redirect strobe;  `trap_pc`  out  XLEN  redirect target
- `csr_wr_mepc_en`, `csr_wr_mcause_en`, `csr_wr_mtval_en`, `csr_wr_mstatus_en`  out  1 each  one-cycle write strobes
- `csr_wr_mepc_mepc`  out  XLEN;  `csr_wr_mcause_exception_code`  out  XLEN-1;  `csr_wr_mcause_interrupt`  out  1;  `csr_wr_mtval`  out  XLEN
- `csr_wr_mstatus_mie`, `csr_wr_mstatus_mpie`  out  1 each

## Operation
- States: IDLE, SAVE, STATUS, RESTORE, REDIRECT.
- IDLE, event check only when `instr_valid`=1. Priority (highest first): enabled interrupt (`mstatus_mie` & `mie_x` & `irq_x`; MEI code 11 > MSI code 3 > MTI code 7) > `illegal` (code 2) > `ecall` (code 11) > `ebreak` (code 3) > `mret`.
- Interrupt/exception: capture pc, cause, interrupt flag, tval (`exc_tval` for illegal, else 0) into registers; -> SAVE. Interrupt preempts the instruction, including an `mret`; mepc = its pc.
- SAVE: pulse mepc/mcause/mtval enables with captured values; -> STATUS.
- STATUS: pulse `csr_wr_mstatus_en`, `mpie`=current `mie`, `mie`=0; -> REDIRECT.
- `mret` (no higher event): -> RESTORE. RESTORE: pulse mstatus write, `mie`=current `mpie`, `mpie`=1; -> REDIRECT.
- REDIRECT: `trap`=1; `trap_pc` = mepc for mret, else `{mtvec_base,2'b0}`; -> IDLE.
- `stall` = (IDLE & event detected) | (state != IDLE). Inputs ignored outside IDLE.
- Interrupt lines that drop after capture do not abort the sequence.

## Timing
- Reset (`rst_b`=0 at posedge): state IDLE, all outputs and capture registers 0. Reset mid-sequence aborts it; no further write strobe or `trap` issued.
- Trap: detect cycle T (combinational `stall`), SAVE T+1, STATUS T+2, REDIRECT T+3, IDLE T+4. Latency to `trap` = 3 cycles.
- mret: detect T, RESTORE T+1, REDIRECT T+2. Latency 2 cycles.
- Write strobes and `trap` are exactly one cycle wide; data outputs 0 when strobe low.
- Earliest next event accepted at T+4 (trap) / T+3 (mret).

## Configuration
- `TRAP_VECTORED_EN` defined: when `mtvec_mode`==1 and captured event is an interrupt, `trap_pc` = `{base,2'b0}` + 4×code (XLEN wrap-around). Exceptions always go to base.
- Undefined: mode ignored, always direct. Either way, mode 2/3 treated as direct.

## Test plan
- `ecall` at pc=0x100, mtvec_base=0x80 (0x200), mie=1: SAVE mepc=0x100 code=11 intr=0 tval=0; STATUS mie=0 mpie=1; `trap` at T+3 with pc=0x200.
- `illegal` with exc_tval=0xFFFFFFFF: mtval=0xFFFFFFFF, code=2.
- `mret`, mepc=0x104, mpie=1: RESTORE mie=1 mpie=1; `trap` at T+2 to 0x104.
- irq_meip+irq_mtip both pending/enabled with `ecall` on same cycle: code=11 intr=1, mepc=pc; with mstatus_mie=0 the `ecall` is taken instead.
- Vectored (macro on, mode=1, base 0x200) MTI: `trap_pc`=0x21C; macro off: 0x200.
- `rst_b`=0 during STATUS: no `trap`, all outputs 0 next cycle, next `ecall` sequences normally.

Source files
------------

// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if: bundles the commit-stage event inputs, the CSR read
// values, and the CSR write strobes / PC redirect outputs of trap_sequencer.
// The "master" side is the core (commit stage plus CSR file).
// The "slave" side is the sequencer itself.
interface trap_sequencer_if #(
  parameter int XLEN = 32
);
  // Commit-stage instruction and decode flags
  logic            instr_valid;
  logic [XLEN-1:0] pc;
  logic            ecall;
  logic            ebreak;
  logic            illegal;
  logic            mret;
  logic [XLEN-1:0] exc_tval;

  // Level-sensitive interrupt pending lines
  logic            irq_msip;
  logic            irq_mtip;
  logic            irq_meip;

  // CSR read values
  logic            csr_rd_mie_msie;
  logic            csr_rd_mie_mtie;
  logic            csr_rd_mie_meie;
  logic            csr_rd_mstatus_mie;
  logic            csr_rd_mstatus_mpie;
  logic [XLEN-3:0] csr_rd_mtvec_base;
  logic [1:0]      csr_rd_mtvec_mode;
  logic [XLEN-1:0] csr_rd_mepc_mepc;

  // Pipeline control and PC redirect
  logic            stall;
  logic            trap;
  logic [XLEN-1:0] trap_pc;

  // CSR write strobes and data
  logic            csr_wr_mepc_en;
  logic            csr_wr_mcause_en;
  logic            csr_wr_mtval_en;
  logic            csr_wr_mstatus_en;
  logic [XLEN-1:0] csr_wr_mepc_mepc;
  logic [XLEN-2:0] csr_wr_mcause_exception_code;
  logic            csr_wr_mcause_interrupt;
  logic [XLEN-1:0] csr_wr_mtval;
  logic            csr_wr_mstatus_mie;
  logic            csr_wr_mstatus_mpie;

  modport master (
    output instr_valid, pc, ecall, ebreak, illegal, mret, exc_tval,
    output irq_msip, irq_mtip, irq_meip,
    output csr_rd_mie_msie, csr_rd_mie_mtie, csr_rd_mie_meie,
    output csr_rd_mstatus_mie, csr_rd_mstatus_mpie,
    output csr_rd_mtvec_base, csr_rd_mtvec_mode, csr_rd_mepc_mepc,
    input  stall, trap, trap_pc,
    input  csr_wr_mepc_en, csr_wr_mcause_en, csr_wr_mtval_en, csr_wr_mstatus_en,
    input  csr_wr_mepc_mepc, csr_wr_mcause_exception_code, csr_wr_mcause_interrupt,
    input  csr_wr_mtval, csr_wr_mstatus_mie, csr_wr_mstatus_mpie
  );

  modport slave (
    input  instr_valid, pc, ecall, ebreak, illegal, mret, exc_tval,
    input  irq_msip, irq_mtip, irq_meip,
    input  csr_rd_mie_msie, csr_rd_mie_mtie, csr_rd_mie_meie,
    input  csr_rd_mstatus_mie, csr_rd_mstatus_mpie,
    input  csr_rd_mtvec_base, csr_rd_mtvec_mode, csr_rd_mepc_mepc,
    output stall, trap, trap_pc,
    output csr_wr_mepc_en, csr_wr_mcause_en, csr_wr_mtval_en, csr_wr_mstatus_en,
    output csr_wr_mepc_mepc, csr_wr_mcause_exception_code, csr_wr_mcause_interrupt,
    output csr_wr_mtval, csr_wr_mstatus_mie, csr_wr_mstatus_mpie
  );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer: arbitrates exceptions raised by the committing instruction
// against enabled machine interrupts, then walks the CSR update sequence
// (mepc/mcause/mtval, then mstatus) before redirecting the PC. It also
// sequences mret (mstatus restore, then redirect to mepc). The core is
// stalled while a sequence is in flight.
//
// Optional feature macro: TRAP_VECTORED_EN. When defined, interrupts taken
// with mtvec.mode == 1 jump to base + 4*cause. Without it, every trap
// goes to the mtvec base. Modes 2 and 3 always behave as direct.
module trap_sequencer #(
  parameter int XLEN = 32
) (
  input logic             clk,
  input logic             rst_b,
  trap_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_STATUS,
    S_RESTORE,
    S_REDIRECT
  } state_t;

  localparam logic [XLEN-2:0] CODE_MEI     = (XLEN-1)'(11);
  localparam logic [XLEN-2:0] CODE_MSI     = (XLEN-1)'(3);
  localparam logic [XLEN-2:0] CODE_MTI     = (XLEN-1)'(7);
  localparam logic [XLEN-2:0] CODE_ILLEGAL = (XLEN-1)'(2);
  localparam logic [XLEN-2:0] CODE_ECALL   = (XLEN-1)'(11);
  localparam logic [XLEN-2:0] CODE_EBREAK  = (XLEN-1)'(3);

  state_t state_q;
  state_t state_d;

  // Values captured when an event is accepted in IDLE
  logic [XLEN-1:0] cap_pc_q;
  logic [XLEN-2:0] cap_code_q;
  logic            cap_intr_q;
  logic [XLEN-1:0] cap_tval_q;
  logic            cap_mret_q;

  // Event decode for the committing instruction
  logic            irq_mei;
  logic            irq_msi;
  logic            irq_mti;
  logic            evt_trap;
  logic            evt_mret;
  logic            evt_any;
  logic            evt_intr;
  logic [XLEN-2:0] evt_code;
  logic [XLEN-1:0] evt_tval;

  // Redirect target selection
  logic [XLEN-1:0] direct_pc;
  logic [XLEN-1:0] vector_pc;

  // Registered-state driven outputs
  logic            stall_c;
  logic            trap_c;
  logic [XLEN-1:0] trap_pc_c;
  logic            mepc_en_c;
  logic            mcause_en_c;
  logic            mtval_en_c;
  logic            mstatus_en_c;
  logic [XLEN-1:0] wr_mepc_c;
  logic [XLEN-2:0] wr_code_c;
  logic            wr_intr_c;
  logic [XLEN-1:0] wr_mtval_c;
  logic            wr_mie_c;
  logic            wr_mpie_c;

  assign irq_mei = bus.csr_rd_mstatus_mie & bus.csr_rd_mie_meie & bus.irq_meip;
  assign irq_msi = bus.csr_rd_mstatus_mie & bus.csr_rd_mie_msie & bus.irq_msip;
  assign irq_mti = bus.csr_rd_mstatus_mie & bus.csr_rd_mie_mtie & bus.irq_mtip;

  // Pick the highest-priority event: interrupts preempt the instruction
  // (even an mret), then illegal, ecall, ebreak, and finally mret itself.
  always_comb begin
    evt_trap = 1'b0;
    evt_mret = 1'b0;
    evt_intr = 1'b0;
    evt_code = '0;
    evt_tval = '0;
    if (bus.instr_valid) begin
      if (irq_mei) begin
        evt_trap = 1'b1;
        evt_intr = 1'b1;
        evt_code = CODE_MEI;
      end else if (irq_msi) begin
        evt_trap = 1'b1;
        evt_intr = 1'b1;
        evt_code = CODE_MSI;
      end else if (irq_mti) begin
        evt_trap = 1'b1;
        evt_intr = 1'b1;
        evt_code = CODE_MTI;
      end else if (bus.illegal) begin
        evt_trap = 1'b1;
        evt_code = CODE_ILLEGAL;
        evt_tval = bus.exc_tval;
      end else if (bus.ecall) begin
        evt_trap = 1'b1;
        evt_code = CODE_ECALL;
      end else if (bus.ebreak) begin
        evt_trap = 1'b1;
        evt_code = CODE_EBREAK;
      end else if (bus.mret) begin
        evt_mret = 1'b1;
      end
    end
  end

  assign evt_any = evt_trap | evt_mret;

  // State register; reset drops any sequence in flight back to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the accepted event so later inputs (including interrupt lines
  // that drop mid-sequence) cannot disturb the sequence.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cap_pc_q   <= '0;
      cap_code_q <= '0;
      cap_intr_q <= 1'b0;
      cap_tval_q <= '0;
      cap_mret_q <= 1'b0;
    end else if ((state_q == S_IDLE) && evt_any) begin
      cap_pc_q   <= bus.pc;
      cap_code_q <= evt_code;
      cap_intr_q <= evt_intr;
      cap_tval_q <= evt_tval;
      cap_mret_q <= evt_mret;
    end
  end

  // Trap target: mtvec base, optionally offset by 4*cause for interrupts.
  always_comb begin
    direct_pc = {bus.csr_rd_mtvec_base, 2'b00};
    vector_pc = direct_pc;
`ifdef TRAP_VECTORED_EN
    if (cap_intr_q && (bus.csr_rd_mtvec_mode == 2'd1)) begin
      vector_pc = direct_pc + {cap_code_q[XLEN-3:0], 2'b00};
    end
`endif
  end

`ifndef TRAP_VECTORED_EN
  logic [1:0] unused_mtvec_mode;
  assign unused_mtvec_mode = bus.csr_rd_mtvec_mode;
`endif

  // Next-state and per-state strobes; data outputs stay zero unless their
  // strobe is high.
  always_comb begin
    state_d      = state_q;
    stall_c      = 1'b0;
    trap_c       = 1'b0;
    trap_pc_c    = '0;
    mepc_en_c    = 1'b0;
    mcause_en_c  = 1'b0;
    mtval_en_c   = 1'b0;
    mstatus_en_c = 1'b0;
    wr_mepc_c    = '0;
    wr_code_c    = '0;
    wr_intr_c    = 1'b0;
    wr_mtval_c   = '0;
    wr_mie_c     = 1'b0;
    wr_mpie_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_c = evt_any;
        if (evt_trap) begin
          state_d = S_SAVE;
        end else if (evt_mret) begin
          state_d = S_RESTORE;
        end
      end
      S_SAVE: begin
        stall_c     = 1'b1;
        mepc_en_c   = 1'b1;
        mcause_en_c = 1'b1;
        mtval_en_c  = 1'b1;
        wr_mepc_c   = cap_pc_q;
        wr_code_c   = cap_code_q;
        wr_intr_c   = cap_intr_q;
        wr_mtval_c  = cap_tval_q;
        state_d     = S_STATUS;
      end
      S_STATUS: begin
        stall_c      = 1'b1;
        mstatus_en_c = 1'b1;
        wr_mie_c     = 1'b0;
        wr_mpie_c    = bus.csr_rd_mstatus_mie;
        state_d      = S_REDIRECT;
      end
      S_RESTORE: begin
        stall_c      = 1'b1;
        mstatus_en_c = 1'b1;
        wr_mie_c     = bus.csr_rd_mstatus_mpie;
        wr_mpie_c    = 1'b1;
        state_d      = S_REDIRECT;
      end
      S_REDIRECT: begin
        stall_c   = 1'b1;
        trap_c    = 1'b1;
        trap_pc_c = cap_mret_q ? bus.csr_rd_mepc_mepc : vector_pc;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.stall                        = stall_c;
  assign bus.trap                         = trap_c;
  assign bus.trap_pc                      = trap_pc_c;
  assign bus.csr_wr_mepc_en               = mepc_en_c;
  assign bus.csr_wr_mcause_en             = mcause_en_c;
  assign bus.csr_wr_mtval_en              = mtval_en_c;
  assign bus.csr_wr_mstatus_en            = mstatus_en_c;
  assign bus.csr_wr_mepc_mepc             = wr_mepc_c;
  assign bus.csr_wr_mcause_exception_code = wr_code_c;
  assign bus.csr_wr_mcause_interrupt      = wr_intr_c;
  assign bus.csr_wr_mtval                 = wr_mtval_c;
  assign bus.csr_wr_mstatus_mie           = wr_mie_c;
  assign bus.csr_wr_mstatus_mpie          = wr_mpie_c;

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed test-plan scenarios with literal expectations,
// followed by randomized stimulus checked every cycle against a
// behavioural model of the trap/mret sequences.
module tb_trap_sequencer;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(XLEN)) bus ();

  trap_sequencer #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int   checks   = 0;
  int   errors   = 0;
  logic checking = 1'b0;

  // Pending reset / CSR read values, applied with the next stimulus
  logic        n_rst_b = 1'b0;
  logic        n_mie   = 1'b0;
  logic        n_mpie  = 1'b0;
  logic        n_msie  = 1'b0;
  logic        n_mtie  = 1'b0;
  logic        n_meie  = 1'b0;
  logic [29:0] n_base  = '0;
  logic [1:0]  n_mode  = '0;
  logic [31:0] n_mepc  = '0;

  // Model: one outstanding sequence, described by its kind and step number
  logic        m_active = 1'b0;
  logic        m_mret   = 1'b0;
  logic        m_intr   = 1'b0;
  int          m_age    = 0;
  logic [31:0] m_pc     = '0;
  logic [30:0] m_code   = '0;
  logic [31:0] m_tval   = '0;

  // Model expectations for the current cycle
  logic        e_stall, e_trap, e_mepc_en, e_mcause_en, e_mtval_en, e_mstatus_en;
  logic        e_intr, e_mie, e_mpie;
  logic [31:0] e_tpc, e_mepc, e_mtval;
  logic [30:0] e_code;

  // Event picked this cycle by the model
  logic        p_found, p_mret, p_intr;
  logic [30:0] p_code;
  logic [31:0] p_tval;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] p,
                               input logic ec, input logic eb, input logic il, input logic mr,
                               input logic [31:0] tv,
                               input logic meip, input logic msip, input logic mtip);
    @(posedge clk);
    #1;
    rst_b                   = n_rst_b;
    bus.instr_valid         = v;
    bus.pc                  = p;
    bus.ecall               = ec;
    bus.ebreak              = eb;
    bus.illegal             = il;
    bus.mret                = mr;
    bus.exc_tval            = tv;
    bus.irq_meip            = meip;
    bus.irq_msip            = msip;
    bus.irq_mtip            = mtip;
    bus.csr_rd_mstatus_mie  = n_mie;
    bus.csr_rd_mstatus_mpie = n_mpie;
    bus.csr_rd_mie_msie     = n_msie;
    bus.csr_rd_mie_mtie     = n_mtie;
    bus.csr_rd_mie_meie     = n_meie;
    bus.csr_rd_mtvec_base   = n_base;
    bus.csr_rd_mtvec_mode   = n_mode;
    bus.csr_rd_mepc_mepc    = n_mepc;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic setCsr(input logic mie, input logic mpie, input logic msie, input logic mtie,
                        input logic meie, input logic [29:0] base, input logic [1:0] mode,
                        input logic [31:0] mepc);
    n_mie  = mie;
    n_mpie = mpie;
    n_msie = msie;
    n_mtie = mtie;
    n_meie = meie;
    n_base = base;
    n_mode = mode;
    n_mepc = mepc;
  endtask

  // Called at the negedge of the detect cycle; walks the three trap steps
  task automatic expectTrapSteps(input string tag, input logic [31:0] epc, input logic [30:0] ecode,
                                 input logic eintr, input logic [31:0] etval, input logic empie,
                                 input logic [31:0] etpc);
    checkOutput({tag, "_detect_stall"}, 32'(bus.stall), 32'd1);
    checkOutput({tag, "_detect_mepc_en"}, 32'(bus.csr_wr_mepc_en), 32'd0);
    idleCycle(); @(negedge clk);
    checkOutput({tag, "_save_mepc_en"}, 32'(bus.csr_wr_mepc_en), 32'd1);
    checkOutput({tag, "_save_mepc"}, bus.csr_wr_mepc_mepc, epc);
    checkOutput({tag, "_save_mcause_en"}, 32'(bus.csr_wr_mcause_en), 32'd1);
    checkOutput({tag, "_save_code"}, 32'(bus.csr_wr_mcause_exception_code), 32'(ecode));
    checkOutput({tag, "_save_intr"}, 32'(bus.csr_wr_mcause_interrupt), 32'(eintr));
    checkOutput({tag, "_save_mtval_en"}, 32'(bus.csr_wr_mtval_en), 32'd1);
    checkOutput({tag, "_save_mtval"}, bus.csr_wr_mtval, etval);
    checkOutput({tag, "_save_trap"}, 32'(bus.trap), 32'd0);
    idleCycle(); @(negedge clk);
    checkOutput({tag, "_status_en"}, 32'(bus.csr_wr_mstatus_en), 32'd1);
    checkOutput({tag, "_status_mie"}, 32'(bus.csr_wr_mstatus_mie), 32'd0);
    checkOutput({tag, "_status_mpie"}, 32'(bus.csr_wr_mstatus_mpie), 32'(empie));
    checkOutput({tag, "_status_trap"}, 32'(bus.trap), 32'd0);
    idleCycle(); @(negedge clk);
    checkOutput({tag, "_redirect_trap"}, 32'(bus.trap), 32'd1);
    checkOutput({tag, "_redirect_pc"}, bus.trap_pc, etpc);
    idleCycle(); @(negedge clk);
    checkOutput({tag, "_done_stall"}, 32'(bus.stall), 32'd0);
    checkOutput({tag, "_done_trap"}, 32'(bus.trap), 32'd0);
  endtask

  // Called at the negedge of the detect cycle; walks the two mret steps
  task automatic expectMretSteps(input string tag, input logic emie, input logic [31:0] etpc);
    checkOutput({tag, "_detect_stall"}, 32'(bus.stall), 32'd1);
    idleCycle(); @(negedge clk);
    checkOutput({tag, "_restore_en"}, 32'(bus.csr_wr_mstatus_en), 32'd1);
    checkOutput({tag, "_restore_mie"}, 32'(bus.csr_wr_mstatus_mie), 32'(emie));
    checkOutput({tag, "_restore_mpie"}, 32'(bus.csr_wr_mstatus_mpie), 32'd1);
    checkOutput({tag, "_restore_mepc_en"}, 32'(bus.csr_wr_mepc_en), 32'd0);
    idleCycle(); @(negedge clk);
    checkOutput({tag, "_redirect_trap"}, 32'(bus.trap), 32'd1);
    checkOutput({tag, "_redirect_pc"}, bus.trap_pc, etpc);
    idleCycle(); @(negedge clk);
    checkOutput({tag, "_done_stall"}, 32'(bus.stall), 32'd0);
  endtask

  // Model event selection: scan interrupt sources in priority order, then
  // the instruction's own exception flags.
  function automatic void pickEvent();
    logic        pend [3];
    logic [30:0] codes [3];
    p_found = 1'b0;
    p_mret  = 1'b0;
    p_intr  = 1'b0;
    p_code  = '0;
    p_tval  = '0;
    pend[0]  = bus.irq_meip & bus.csr_rd_mie_meie;
    pend[1]  = bus.irq_msip & bus.csr_rd_mie_msie;
    pend[2]  = bus.irq_mtip & bus.csr_rd_mie_mtie;
    codes[0] = 31'd11;
    codes[1] = 31'd3;
    codes[2] = 31'd7;
    if (!bus.instr_valid) return;
    if (bus.csr_rd_mstatus_mie) begin
      for (int i = 0; i < 3; i++) begin
        if (pend[i]) begin
          p_found = 1'b1;
          p_intr  = 1'b1;
          p_code  = codes[i];
          return;
        end
      end
    end
    p_found = 1'b1;
    if (bus.illegal) begin
      p_code = 31'd2;
      p_tval = bus.exc_tval;
    end else if (bus.ecall) begin
      p_code = 31'd11;
    end else if (bus.ebreak) begin
      p_code = 31'd3;
    end else if (bus.mret) begin
      p_mret = 1'b1;
    end else begin
      p_found = 1'b0;
    end
  endfunction

  // Per-cycle compare against the model, then advance the model one cycle
  always @(negedge clk) begin
    if (checking) begin
      {e_stall, e_trap, e_mepc_en, e_mcause_en, e_mtval_en, e_mstatus_en} = '0;
      {e_intr, e_mie, e_mpie} = '0;
      e_tpc = '0; e_mepc = '0; e_mtval = '0; e_code = '0;
      pickEvent();
      if (!m_active) begin
        e_stall = p_found;
      end else begin
        e_stall = 1'b1;
        if (m_mret && m_age == 1) begin
          e_mstatus_en = 1'b1;
          e_mie        = bus.csr_rd_mstatus_mpie;
          e_mpie       = 1'b1;
        end else if (m_mret) begin
          e_trap = 1'b1;
          e_tpc  = bus.csr_rd_mepc_mepc;
        end else if (m_age == 1) begin
          {e_mepc_en, e_mcause_en, e_mtval_en} = 3'b111;
          e_mepc  = m_pc;
          e_code  = m_code;
          e_intr  = m_intr;
          e_mtval = m_tval;
        end else if (m_age == 2) begin
          e_mstatus_en = 1'b1;
          e_mpie       = bus.csr_rd_mstatus_mie;
        end else begin
          e_trap = 1'b1;
          e_tpc  = {bus.csr_rd_mtvec_base, 2'b00};
`ifdef TRAP_VECTORED_EN
          if (m_intr && bus.csr_rd_mtvec_mode == 2'd1) e_tpc = e_tpc + 32'(m_code) * 32'd4;
`endif
        end
      end
      checkOutput("mdl_stall", 32'(bus.stall), 32'(e_stall));
      checkOutput("mdl_trap", 32'(bus.trap), 32'(e_trap));
      checkOutput("mdl_trap_pc", bus.trap_pc, e_tpc);
      checkOutput("mdl_mepc_en", 32'(bus.csr_wr_mepc_en), 32'(e_mepc_en));
      checkOutput("mdl_mcause_en", 32'(bus.csr_wr_mcause_en), 32'(e_mcause_en));
      checkOutput("mdl_mtval_en", 32'(bus.csr_wr_mtval_en), 32'(e_mtval_en));
      checkOutput("mdl_mstatus_en", 32'(bus.csr_wr_mstatus_en), 32'(e_mstatus_en));
      checkOutput("mdl_mepc", bus.csr_wr_mepc_mepc, e_mepc);
      checkOutput("mdl_code", 32'(bus.csr_wr_mcause_exception_code), 32'(e_code));
      checkOutput("mdl_intr", 32'(bus.csr_wr_mcause_interrupt), 32'(e_intr));
      checkOutput("mdl_mtval", bus.csr_wr_mtval, e_mtval);
      checkOutput("mdl_mstatus_mie", 32'(bus.csr_wr_mstatus_mie), 32'(e_mie));
      checkOutput("mdl_mstatus_mpie", 32'(bus.csr_wr_mstatus_mpie), 32'(e_mpie));

      if (!rst_b) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (p_found) begin
          m_active = 1'b1;
          m_age    = 1;
          m_mret   = p_mret;
          m_intr   = p_intr;
          m_code   = p_code;
          m_tval   = p_tval;
          m_pc     = bus.pc;
        end
      end else if (m_age >= (m_mret ? 2 : 3)) begin
        m_active = 1'b0;
      end else begin
        m_age++;
      end
    end
  end

  initial begin
    bus.instr_valid = 1'b0; bus.pc = '0; bus.ecall = 1'b0; bus.ebreak = 1'b0;
    bus.illegal = 1'b0; bus.mret = 1'b0; bus.exc_tval = '0;
    bus.irq_meip = 1'b0; bus.irq_msip = 1'b0; bus.irq_mtip = 1'b0;
    bus.csr_rd_mstatus_mie = 1'b0; bus.csr_rd_mstatus_mpie = 1'b0;
    bus.csr_rd_mie_msie = 1'b0; bus.csr_rd_mie_mtie = 1'b0; bus.csr_rd_mie_meie = 1'b0;
    bus.csr_rd_mtvec_base = '0; bus.csr_rd_mtvec_mode = '0; bus.csr_rd_mepc_mepc = '0;

    // Reset state
    n_rst_b = 1'b0;
    idleCycle();
    checking = 1'b1;
    @(negedge clk);
    checkOutput("rst_stall", 32'(bus.stall), 32'd0);
    checkOutput("rst_trap", 32'(bus.trap), 32'd0);
    checkOutput("rst_mepc_en", 32'(bus.csr_wr_mepc_en), 32'd0);
    checkOutput("rst_mstatus_en", 32'(bus.csr_wr_mstatus_en), 32'd0);
    n_rst_b = 1'b1;
    idleCycle(); @(negedge clk);

    // ecall at 0x100, mtvec 0x200, mie=1
    setCsr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'h80, 2'd0, 32'h0);
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expectTrapSteps("ecall", 32'h100, 31'd11, 1'b0, 32'h0, 1'b1, 32'h200);

    // illegal with tval all-ones, global mie clear
    setCsr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 30'h80, 2'd0, 32'h0);
    applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expectTrapSteps("illegal", 32'h300, 31'd2, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h200);

    // ebreak outranks mret on the same instruction
    applyStimulus(1'b1, 32'h310, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expectTrapSteps("ebreak", 32'h310, 31'd3, 1'b0, 32'h0, 1'b0, 32'h200);

    // mret with mepc 0x104, mpie=1
    setCsr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 30'h80, 2'd0, 32'h104);
    applyStimulus(1'b1, 32'h320, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expectMretSteps("mret", 1'b1, 32'h104);

    // MEI and MTI pending with ecall: MEI wins as an interrupt
    setCsr(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 30'h80, 2'd0, 32'h0);
    applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    expectTrapSteps("irq_mei", 32'h400, 31'd11, 1'b1, 32'h0, 1'b1, 32'h200);

    // Same, globally disabled: ecall taken instead
    setCsr(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 30'h80, 2'd0, 32'h0);
    applyStimulus(1'b1, 32'h404, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    expectTrapSteps("irq_masked", 32'h404, 31'd11, 1'b0, 32'h0, 1'b0, 32'h200);

    // MSI preempts an mret
    setCsr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 30'h80, 2'd0, 32'h104);
    applyStimulus(1'b1, 32'h408, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    expectTrapSteps("msi_vs_mret", 32'h408, 31'd3, 1'b1, 32'h0, 1'b1, 32'h200);

    // MTI with vectored mode
    setCsr(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 30'h80, 2'd1, 32'h0);
    applyStimulus(1'b1, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
`ifdef TRAP_VECTORED_EN
    expectTrapSteps("mti_vec", 32'h600, 31'd7, 1'b1, 32'h0, 1'b1, 32'h21C);
`else
    expectTrapSteps("mti_vec", 32'h600, 31'd7, 1'b1, 32'h0, 1'b1, 32'h200);
`endif

    // Reset asserted during STATUS
    setCsr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'h80, 2'd0, 32'h0);
    applyStimulus(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rstmid_detect_stall", 32'(bus.stall), 32'd1);
    idleCycle(); @(negedge clk);
    checkOutput("rstmid_save_mepc_en", 32'(bus.csr_wr_mepc_en), 32'd1);
    n_rst_b = 1'b0;
    idleCycle(); @(negedge clk);
    checkOutput("rstmid_status_trap", 32'(bus.trap), 32'd0);
    n_rst_b = 1'b1;
    idleCycle(); @(negedge clk);
    checkOutput("rstmid_after_stall", 32'(bus.stall), 32'd0);
    checkOutput("rstmid_after_trap", 32'(bus.trap), 32'd0);
    checkOutput("rstmid_after_trap_pc", bus.trap_pc, 32'h0);
    checkOutput("rstmid_after_mstatus_en", 32'(bus.csr_wr_mstatus_en), 32'd0);
    checkOutput("rstmid_after_mepc_en", 32'(bus.csr_wr_mepc_en), 32'd0);
    idleCycle(); @(negedge clk);
    checkOutput("rstmid_late_trap", 32'(bus.trap), 32'd0);
    applyStimulus(1'b1, 32'h504, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expectTrapSteps("post_rst", 32'h504, 31'd11, 1'b0, 32'h0, 1'b1, 32'h200);

    // Randomized phase, checked by the model alone
    for (int i = 0; i < 3000; i++) begin
      n_rst_b = ($urandom_range(0, 149) != 0);
      setCsr($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 30'($urandom),
             2'($urandom_range(0, 3)), $urandom);
      applyStimulus($urandom_range(0, 9) < 6, $urandom,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0);
    end
    n_rst_b = 1'b1;
    for (int i = 0; i < 6; i++) idleCycle();
    @(negedge clk);
    checking = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
